// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} ctrl_state_e;
  typedef logic [4:0] reg_idx;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipe_hazard_ctrl_if import pipe_hazard_ctrl_pkg::*; #(parameter int CNT_W = 32);
  reg_idx rs1_idx_D;
  reg_idx rs2_idx_D;
  logic use_rs1_D;
  logic use_rs2_D;
  reg_idx rd_idx_E;
  logic wb_en_E;
  logic is_load_E;
  logic jb;
  logic mdu_op_E;
  logic mdu_done;
  logic dmem_req_M;
  logic dmem_ready;
  logic stall_F;
  logic stall_D;
  logic stall_E;
  logic stall_M;
  logic flush_D;
  logic bubble_E;
  logic bubble_M;
  logic bubble_W;
  logic mdu_go;
  logic timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  modport slave (
    input rs1_idx_D, rs2_idx_D, use_rs1_D, use_rs2_D, rd_idx_E, wb_en_E, is_load_E,
    input jb, mdu_op_E, mdu_done, dmem_req_M, dmem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, bubble_M, bubble_W,
    output mdu_go, timeout_err, stall_cnt
  );
  modport master (
    output rs1_idx_D, rs2_idx_D, use_rs1_D, use_rs2_D, rd_idx_E, wb_en_E, is_load_E,
    output jb, mdu_op_E, mdu_done, dmem_req_M, dmem_ready,
    input stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, bubble_M, bubble_W,
    input mdu_go, timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use comparator between the load in E and the reader in D
module pipe_hazard_ctrl_hazard_detect import pipe_hazard_ctrl_pkg::*; (
  input  reg_idx i_rs1_idx,
  input  reg_idx i_rs2_idx,
  input  logic   i_use_rs1,
  input  logic   i_use_rs2,
  input  reg_idx i_rd_idx,
  input  logic   i_wb_en,
  input  logic   i_is_load,
  output logic   o_luh
);
  assign o_luh = i_is_load && i_wb_en && i_rd_idx != '0 &&
                 ((i_use_rs1 && i_rs1_idx == i_rd_idx) || (i_use_rs2 && i_rs2_idx == i_rd_idx));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler with wait-state FSM, watchdog and stall counter
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  ctrl_state_e r_state, w_nxt;
  logic [WD_W-1:0] r_wd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic w_luh, w_mem_stall, w_wd_exp;
  logic w_stall_F, w_stall_D, w_stall_E, w_stall_M;
  logic w_flush_D, w_bubble_E, w_bubble_M, w_bubble_W, w_mdu_go, w_timeout;
  pipe_hazard_ctrl_hazard_detect u_hd (
    .i_rs1_idx (bus.rs1_idx_D),
    .i_rs2_idx (bus.rs2_idx_D),
    .i_use_rs1 (bus.use_rs1_D),
    .i_use_rs2 (bus.use_rs2_D),
    .i_rd_idx  (bus.rd_idx_E),
    .i_wb_en   (bus.wb_en_E),
    .i_is_load (bus.is_load_E),
    .o_luh     (w_luh)
  );
  assign w_mem_stall = bus.dmem_req_M && !bus.dmem_ready;
  assign w_wd_exp    = r_wd == WD_W'(TIMEOUT - 1);
  // next state and pipeline controls; in RUN the first matching hazard wins
  always_comb begin
    w_nxt      = r_state;
    w_stall_F  = 1'b0;
    w_stall_D  = 1'b0;
    w_stall_E  = 1'b0;
    w_stall_M  = 1'b0;
    w_flush_D  = 1'b0;
    w_bubble_E = 1'b0;
    w_bubble_M = 1'b0;
    w_bubble_W = 1'b0;
    w_mdu_go   = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      RUN:
        if (w_mem_stall) begin
          {w_stall_F, w_stall_D, w_stall_E, w_stall_M, w_bubble_W} = '1;
          w_nxt = MEM_WAIT;
        end else if (bus.mdu_op_E) begin
          {w_mdu_go, w_stall_F, w_stall_D, w_stall_E, w_bubble_M} = '1;
          w_nxt = MDU_WAIT;
        end else if (bus.jb) begin
          {w_flush_D, w_bubble_E} = '1;
        end else if (w_luh) begin
          {w_stall_F, w_stall_D, w_bubble_E} = '1;
        end
      MDU_WAIT:
        if (bus.mdu_done) w_nxt = RUN;
        else begin
          {w_stall_F, w_stall_D, w_stall_E, w_bubble_M} = '1;
          w_timeout = w_wd_exp;
          w_nxt = w_wd_exp ? RUN : MDU_WAIT;
        end
      MEM_WAIT:
        if (bus.dmem_ready) w_nxt = RUN;
        else begin
          {w_stall_F, w_stall_D, w_stall_E, w_stall_M, w_bubble_W} = '1;
          w_timeout = w_wd_exp;
          w_nxt = w_wd_exp ? RUN : MEM_WAIT;
        end
      default: w_nxt = RUN;
    endcase
  end
  assign {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M, bus.flush_D,
          bus.bubble_E, bus.bubble_M, bus.bubble_W, bus.mdu_go, bus.timeout_err} =
         {10{rst}} & {w_stall_F, w_stall_D, w_stall_E, w_stall_M, w_flush_D,
                      w_bubble_E, w_bubble_M, w_bubble_W, w_mdu_go, w_timeout};
  assign bus.stall_cnt = r_stall_cnt;
  // state, watchdog (runs only across wait cycles) and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wd        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_nxt;
      r_wd        <= (r_state == RUN || w_nxt == RUN) ? '0 : r_wd + 1'b1;
      r_stall_cnt <= (w_stall_F && !(&r_stall_cnt)) ? r_stall_cnt + 1'b1 : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario checks for the hazard controller
module tb_pipe_hazard_ctrl;
  localparam logic [9:0] NONE     = 10'b0000_0000_00;
  localparam logic [9:0] LUH      = 10'b1100_0100_00;
  localparam logic [9:0] JB       = 10'b0000_1100_00;
  localparam logic [9:0] MDU_ISS  = 10'b1110_0010_10;
  localparam logic [9:0] MDU_HOLD = 10'b1110_0010_00;
  localparam logic [9:0] MEM      = 10'b1111_0001_00;
  localparam logic [9:0] TO       = 10'b1110_0010_01;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_pass = 0;
  int n_chk = 0;
  logic [9:0] ctl_a, ctl_w;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) ifw ();
  pipe_hazard_ctrl #(.TIMEOUT(256), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(32)) dut_w (.clk(clk), .rst(rst), .bus(ifw.slave));
  assign ifw.rs1_idx_D  = ifa.rs1_idx_D;
  assign ifw.rs2_idx_D  = ifa.rs2_idx_D;
  assign ifw.use_rs1_D  = ifa.use_rs1_D;
  assign ifw.use_rs2_D  = ifa.use_rs2_D;
  assign ifw.rd_idx_E   = ifa.rd_idx_E;
  assign ifw.wb_en_E    = ifa.wb_en_E;
  assign ifw.is_load_E  = ifa.is_load_E;
  assign ifw.jb         = ifa.jb;
  assign ifw.mdu_op_E   = ifa.mdu_op_E;
  assign ifw.mdu_done   = ifa.mdu_done;
  assign ifw.dmem_req_M = ifa.dmem_req_M;
  assign ifw.dmem_ready = ifa.dmem_ready;
  assign ctl_a = {ifa.stall_F, ifa.stall_D, ifa.stall_E, ifa.stall_M, ifa.flush_D,
                  ifa.bubble_E, ifa.bubble_M, ifa.bubble_W, ifa.mdu_go, ifa.timeout_err};
  assign ctl_w = {ifw.stall_F, ifw.stall_D, ifw.stall_E, ifw.stall_M, ifw.flush_D,
                  ifw.bubble_E, ifw.bubble_M, ifw.bubble_W, ifw.mdu_go, ifw.timeout_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    ifa.rs1_idx_D = '0; ifa.rs2_idx_D = '0; ifa.use_rs1_D = 0; ifa.use_rs2_D = 0;
    ifa.rd_idx_E = '0; ifa.wb_en_E = 0; ifa.is_load_E = 0; ifa.jb = 0;
    ifa.mdu_op_E = 0; ifa.mdu_done = 0; ifa.dmem_req_M = 0; ifa.dmem_ready = 0;
  endtask

  task automatic test_reset;
    clr;
    rst = 0;
    ifa.mdu_op_E = 1; ifa.jb = 1; ifa.dmem_req_M = 1;
    tick; tick;
    n_chk++; if (ctl_a !== NONE) $display("FAIL reset_ctl got=%b exp=%b", ctl_a, NONE); else n_pass++;
    n_chk++; if (ctl_w !== NONE) $display("FAIL reset_ctl_w got=%b exp=%b", ctl_w, NONE); else n_pass++;
    n_chk++; if (ifa.stall_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", ifa.stall_cnt); else n_pass++;
    clr;
    rst = 1;
    tick;
  endtask

  task automatic test_load_use;
    ifa.is_load_E = 1; ifa.wb_en_E = 1; ifa.rd_idx_E = 5; ifa.rs1_idx_D = 5; ifa.use_rs1_D = 1;
    #1;
    n_chk++; if (ctl_a !== LUH) $display("FAIL luh_rs1 got=%b exp=%b", ctl_a, LUH); else n_pass++;
    tick;
    ifa.is_load_E = 0;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL luh_release got=%b exp=%b", ctl_a, NONE); else n_pass++;
    tick;
    ifa.is_load_E = 1; ifa.use_rs1_D = 0; ifa.rs1_idx_D = 0; ifa.rs2_idx_D = 5; ifa.use_rs2_D = 1;
    #1;
    n_chk++; if (ctl_a !== LUH) $display("FAIL luh_rs2 got=%b exp=%b", ctl_a, LUH); else n_pass++;
    tick;
    ifa.use_rs2_D = 0;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL luh_nouse got=%b exp=%b", ctl_a, NONE); else n_pass++;
    tick;
    ifa.rd_idx_E = 0; ifa.rs1_idx_D = 0; ifa.use_rs1_D = 1;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL luh_x0 got=%b exp=%b", ctl_a, NONE); else n_pass++;
    tick;
    ifa.rd_idx_E = 5; ifa.rs1_idx_D = 5; ifa.wb_en_E = 0;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL luh_nowb got=%b exp=%b", ctl_a, NONE); else n_pass++;
    tick;
    clr;
    #1;
    n_chk++; if (ifa.stall_cnt !== 32'd2) $display("FAIL luh_cnt got=%0d exp=2", ifa.stall_cnt); else n_pass++;
  endtask

  task automatic test_branch;
    clr;
    ifa.jb = 1;
    #1;
    n_chk++; if (ctl_a !== JB) $display("FAIL jb got=%b exp=%b", ctl_a, JB); else n_pass++;
    tick;
    ifa.is_load_E = 1; ifa.wb_en_E = 1; ifa.rd_idx_E = 7; ifa.rs1_idx_D = 7; ifa.use_rs1_D = 1;
    #1;
    n_chk++; if (ctl_a !== JB) $display("FAIL jb_over_luh got=%b exp=%b", ctl_a, JB); else n_pass++;
    tick;
    clr;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL jb_idle got=%b exp=%b", ctl_a, NONE); else n_pass++;
    n_chk++; if (ifa.stall_cnt !== 32'd2) $display("FAIL jb_cnt got=%0d exp=2", ifa.stall_cnt); else n_pass++;
  endtask

  task automatic test_mdu;
    int bad = 0;
    int gos = 0;
    clr;
    ifa.mdu_op_E = 1;
    #1;
    n_chk++; if (ctl_a !== MDU_ISS) $display("FAIL mdu_issue got=%b exp=%b", ctl_a, MDU_ISS); else n_pass++;
    gos += int'(ifa.mdu_go);
    tick;
    for (int i = 0; i < 33; i++) begin
      #1;
      if (ctl_a !== MDU_HOLD) bad++;
      gos += int'(ifa.mdu_go);
      tick;
    end
    n_chk++; if (bad !== 0) $display("FAIL mdu_hold got=%0d bad_cycles exp=0", bad); else n_pass++;
    ifa.mdu_done = 1;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL mdu_done got=%b exp=%b", ctl_a, NONE); else n_pass++;
    gos += int'(ifa.mdu_go);
    tick;
    clr;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL mdu_after got=%b exp=%b", ctl_a, NONE); else n_pass++;
    n_chk++; if (gos !== 1) $display("FAIL mdu_go_count got=%0d exp=1", gos); else n_pass++;
    n_chk++; if (ifa.stall_cnt !== 32'd36) $display("FAIL mdu_cnt got=%0d exp=36", ifa.stall_cnt); else n_pass++;
  endtask

  task automatic test_memory;
    int bad = 0;
    int gos = 0;
    clr;
    ifa.dmem_req_M = 1; ifa.mdu_op_E = 1;
    #1;
    n_chk++; if (ctl_a !== MEM) $display("FAIL mem_enter got=%b exp=%b", ctl_a, MEM); else n_pass++;
    tick;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ctl_a !== MEM) bad++;
      gos += int'(ifa.mdu_go);
      tick;
    end
    n_chk++; if (bad !== 0) $display("FAIL mem_hold got=%0d bad_cycles exp=0", bad); else n_pass++;
    ifa.dmem_ready = 1;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL mem_ready got=%b exp=%b", ctl_a, NONE); else n_pass++;
    n_chk++; if (gos !== 0) $display("FAIL mem_no_go got=%0d exp=0", gos); else n_pass++;
    tick;
    ifa.dmem_req_M = 0; ifa.dmem_ready = 0;
    #1;
    n_chk++; if (ctl_a !== MDU_ISS) $display("FAIL mem_mdu_reissue got=%b exp=%b", ctl_a, MDU_ISS); else n_pass++;
    tick;
    #1;
    n_chk++; if (ctl_a !== MDU_HOLD) $display("FAIL mem_mdu_wait got=%b exp=%b", ctl_a, MDU_HOLD); else n_pass++;
    tick;
    ifa.mdu_done = 1; ifa.mdu_op_E = 0;
    #1;
    tick;
    clr;
    #1;
    n_chk++; if (ifa.stall_cnt !== 32'd42) $display("FAIL mem_cnt got=%0d exp=42", ifa.stall_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid;
    clr;
    ifa.dmem_req_M = 1;
    tick;
    #1;
    n_chk++; if (ctl_a !== MEM) $display("FAIL rmid_wait got=%b exp=%b", ctl_a, MEM); else n_pass++;
    tick;
    rst = 0; ifa.mdu_op_E = 1; ifa.jb = 1;
    #1;
    n_chk++; if (ctl_a !== NONE) $display("FAIL rmid_forced got=%b exp=%b", ctl_a, NONE); else n_pass++;
    tick;
    rst = 1;
    clr;
    ifa.jb = 1;
    #1;
    n_chk++; if (ctl_a !== JB) $display("FAIL rmid_state_run got=%b exp=%b", ctl_a, JB); else n_pass++;
    n_chk++; if (ifa.stall_cnt !== 32'd0) $display("FAIL rmid_cnt got=%0d exp=0", ifa.stall_cnt); else n_pass++;
    tick;
    clr;
  endtask

  task automatic test_watchdog;
    int bad = 0;
    clr;
    ifa.mdu_op_E = 1;
    #1;
    n_chk++; if (ctl_w !== MDU_ISS) $display("FAIL wd_issue got=%b exp=%b", ctl_w, MDU_ISS); else n_pass++;
    tick;
    ifa.mdu_op_E = 0;
    for (int i = 1; i < 8; i++) begin
      #1;
      if (ctl_w !== MDU_HOLD) bad++;
      tick;
    end
    n_chk++; if (bad !== 0) $display("FAIL wd_hold got=%0d bad_cycles exp=0", bad); else n_pass++;
    #1;
    n_chk++; if (ctl_w !== TO) $display("FAIL wd_fire got=%b exp=%b", ctl_w, TO); else n_pass++;
    n_chk++; if (ctl_a !== MDU_HOLD) $display("FAIL wd_long_timeout got=%b exp=%b", ctl_a, MDU_HOLD); else n_pass++;
    tick;
    #1;
    n_chk++; if (ctl_w !== NONE) $display("FAIL wd_released got=%b exp=%b", ctl_w, NONE); else n_pass++;
    n_chk++; if (ifw.stall_cnt !== 32'd9) $display("FAIL wd_cnt got=%0d exp=9", ifw.stall_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_mdu;
    test_memory;
    test_reset_mid;
    test_watchdog;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
